// File: rtl/servo_pkg.sv
// Shared constants and FSM encoding for the servo PWM path and the
// marble-dispense controller that drives it.
package servo_pkg;

    localparam int CLK_HZ            = 100_000_000;
    localparam int PERIOD_CYCLES_DEF = 2_000_000;
    localparam int MIN_PULSE_DEF     = 50_000;
    localparam int MAX_PULSE_DEF     = 250_000;
    localparam int SETTLE_FRAMES_DEF = 25;
    localparam int WIDTH_DEF         = 21;

    localparam int ANGLE_DISPENSE = 230_000;
    localparam int ANGLE_HOME     = 65_000;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        MOVING   = 2'd1,
        HOLDING  = 2'd2
    } servo_state_e;

endpackage

// File: rtl/servo_pwm_gen_if.sv
// Link between the dispense controller (master) and the servo PWM generator (slave).
interface servo_pwm_gen_if #(
    parameter int WIDTH = 21
);
    logic [WIDTH-1:0] angle_value;
    logic [WIDTH-1:0] pulse_width;
    logic             settled;
    logic             frame_start;

    modport master (output angle_value, input pulse_width, settled, frame_start);
    modport slave  (input angle_value, output pulse_width, settled, frame_start);
endinterface

// File: rtl/servo_frame_timer.sv
// Wrapping frame counter; the first edge after reset opens a fresh frame at count 0.
module servo_frame_timer #(
    parameter int PERIOD_CYCLES = 2_000_000,
    parameter int CW            = 21
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [CW-1:0] frame_cnt,
    output logic          sample,
    output logic          frame_start
);

    logic          started_q, started_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          frame_start_q, frame_start_d;

    always_comb begin
        sample        = !started_q || (cnt_q == CW'(PERIOD_CYCLES - 1));
        started_d     = 1'b1;
        cnt_d         = sample ? '0 : cnt_q + CW'(1);
        frame_start_d = sample;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q     <= 1'b0;
            cnt_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            started_q     <= started_d;
            cnt_q         <= cnt_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign frame_cnt   = cnt_q;
    assign frame_start = frame_start_q;

endmodule

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: samples and clamps the requested width once per frame.
//   state    | meaning
//   RELEASED | shadow is 0, no pulses
//   MOVING   | new non-zero width, fewer than SETTLE_FRAMES matching frames
//   HOLDING  | width unchanged for SETTLE_FRAMES frames, settled = 1
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int PERIOD_CYCLES = PERIOD_CYCLES_DEF,
    parameter int MIN_PULSE     = MIN_PULSE_DEF,
    parameter int MAX_PULSE     = MAX_PULSE_DEF,
    parameter int SETTLE_FRAMES = SETTLE_FRAMES_DEF,
    parameter int WIDTH         = WIDTH_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    servo_pwm_gen_if.slave  ang,
    output logic            servo_pwm
);

    localparam int CW   = $clog2(PERIOD_CYCLES);
    localparam int CMPW = ((CW > WIDTH) ? CW : WIDTH) + 1;
    localparam int SW   = $clog2(SETTLE_FRAMES + 1);

    logic [CW-1:0]    frame_cnt;
    logic             sample;
    logic             frame_start;

    logic [WIDTH-1:0] clamped;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
    servo_state_e     state_q, state_d;
    logic             servo_pwm_q, servo_pwm_d;
    logic             settled_q, settled_d;

    servo_frame_timer #(
        .PERIOD_CYCLES (PERIOD_CYCLES),
        .CW            (CW)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_cnt   (frame_cnt),
        .sample      (sample),
        .frame_start (frame_start)
    );

    always_comb begin
        clamped = ang.angle_value;
        if (ang.angle_value == '0)
            clamped = '0;
        else if (ang.angle_value < WIDTH'(MIN_PULSE))
            clamped = WIDTH'(MIN_PULSE);
        else if (ang.angle_value > WIDTH'(MAX_PULSE))
            clamped = WIDTH'(MAX_PULSE);
    end

    always_comb begin
        shadow_d     = shadow_q;
        settle_cnt_d = settle_cnt_q;
        state_d      = state_q;
        if (sample) begin
            shadow_d = clamped;
            if (clamped != shadow_q) begin
                settle_cnt_d = '0;
                state_d      = (clamped == '0) ? RELEASED : MOVING;
            end else if (clamped != '0) begin
                if (settle_cnt_q < SW'(SETTLE_FRAMES))
                    settle_cnt_d = settle_cnt_q + SW'(1);
                state_d = (settle_cnt_d == SW'(SETTLE_FRAMES)) ? HOLDING : MOVING;
            end else begin
                settle_cnt_d = '0;
                state_d      = RELEASED;
            end
            servo_pwm_d = (clamped != '0);
        end else begin
            // compare against the count the next cycle will carry, so the pin is registered
            servo_pwm_d = (CMPW'(frame_cnt) + CMPW'(1)) < CMPW'(shadow_q);
        end
        settled_d = (state_d == HOLDING);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q     <= '0;
            settle_cnt_q <= '0;
            state_q      <= RELEASED;
            servo_pwm_q  <= 1'b0;
            settled_q    <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            settle_cnt_q <= settle_cnt_d;
            state_q      <= state_d;
            servo_pwm_q  <= servo_pwm_d;
            settled_q    <= settled_d;
        end
    end

    assign servo_pwm       = servo_pwm_q;
    assign ang.pulse_width = shadow_q;
    assign ang.settled     = settled_q;
    assign ang.frame_start = frame_start;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen with a 1000-cycle frame and 50..250 clamp.
module tb_servo_pwm_gen;

    localparam int P      = 1000;
    localparam int MINP   = 50;
    localparam int MAXP   = 250;
    localparam int SETTLE = 3;
    localparam int W      = 21;

    logic clk = 1'b0;
    logic rst_n;
    logic servo_pwm;
    logic prev_pwm = 1'b0;
    int   total = 0;
    int   passed = 0;

    servo_pwm_gen_if #(.WIDTH(W)) ang ();

    servo_pwm_gen #(
        .PERIOD_CYCLES (P),
        .MIN_PULSE     (MINP),
        .MAX_PULSE     (MAXP),
        .SETTLE_FRAMES (SETTLE),
        .WIDTH         (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ang       (ang),
        .servo_pwm (servo_pwm)
    );

    always #5 clk = ~clk;

    // Called on the negedge of a frame's first cycle; returns on the next frame's first cycle.
    task automatic measure_frame(input int chg_at, input logic [W-1:0] chg_val,
                                 output int hi, output int rises, output int fs,
                                 output bit fs0, output logic [W-1:0] pw,
                                 output logic st, output bit stable);
        hi = 0; rises = 0; fs = 0; stable = 1'b1;
        fs0 = (ang.frame_start === 1'b1);
        pw  = ang.pulse_width;
        st  = ang.settled;
        for (int i = 0; i < P; i++) begin
            if (i == chg_at) ang.angle_value = chg_val;
            if (servo_pwm === 1'b1) hi++;
            if (servo_pwm === 1'b1 && prev_pwm !== 1'b1) rises++;
            if (ang.frame_start === 1'b1) fs++;
            if (ang.pulse_width !== pw || ang.settled !== st) stable = 1'b0;
            prev_pwm = servo_pwm;
            @(negedge clk);
        end
    endtask

    task automatic sync_frame(input string name);
        int n = 0;
        while (ang.frame_start !== 1'b1 && n < 2 * P) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (ang.frame_start !== 1'b1)
            $display("FAIL %s sync: frame_start=%b after %0d cycles, want 1", name, ang.frame_start, n);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ang.angle_value = W'(230);
        repeat (5) @(negedge clk);
        total++; if (servo_pwm !== 1'b0)        $display("FAIL reset servo_pwm: got %b want 0", servo_pwm); else passed++;
        total++; if (ang.frame_start !== 1'b0)  $display("FAIL reset frame_start: got %b want 0", ang.frame_start); else passed++;
        total++; if (ang.settled !== 1'b0)      $display("FAIL reset settled: got %b want 0", ang.settled); else passed++;
        total++; if (ang.pulse_width !== '0)    $display("FAIL reset pulse_width: got %0d want 0", ang.pulse_width); else passed++;
        rst_n = 1'b1;
        prev_pwm = 1'b0;
    endtask

    task automatic test_steady();
        int hi, rises, fs; bit fs0, stable; logic [W-1:0] pw; logic st;
        sync_frame("steady");
        for (int f = 0; f < 5; f++) begin
            measure_frame(-1, '0, hi, rises, fs, fs0, pw, st, stable);
            total++; if (hi !== 230)              $display("FAIL steady f%0d high: got %0d want 230", f, hi); else passed++;
            total++; if (rises !== 1)             $display("FAIL steady f%0d rises: got %0d want 1", f, rises); else passed++;
            total++; if (fs !== 1 || !fs0)        $display("FAIL steady f%0d frame_start: got %0d (first=%0d) want 1", f, fs, fs0); else passed++;
            total++; if (pw !== W'(230))          $display("FAIL steady f%0d pulse_width: got %0d want 230", f, pw); else passed++;
            total++; if (st !== (f >= 3))         $display("FAIL steady f%0d settled: got %b want %b", f, st, (f >= 3)); else passed++;
            total++; if (!stable)                 $display("FAIL steady f%0d midframe change: got unstable want stable", f); else passed++;
        end
    endtask

    task automatic test_clamp();
        int hi, rises, fs; bit fs0, stable; logic [W-1:0] pw; logic st;
        int set_v[9]  = '{10, 20, 20, 20, 400, 250, 250, 250, 230};
        int exp_hi[9] = '{230, 50, 50, 50, 50, 250, 250, 250, 250};
        bit exp_st[9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        for (int f = 0; f < 9; f++) begin
            ang.angle_value = W'(set_v[f]);
            measure_frame(-1, '0, hi, rises, fs, fs0, pw, st, stable);
            total++; if (hi !== exp_hi[f])        $display("FAIL clamp f%0d high: got %0d want %0d", f, hi, exp_hi[f]); else passed++;
            total++; if (pw !== W'(exp_hi[f]))    $display("FAIL clamp f%0d pulse_width: got %0d want %0d", f, pw, exp_hi[f]); else passed++;
            total++; if (st !== exp_st[f])        $display("FAIL clamp f%0d settled: got %b want %b", f, st, exp_st[f]); else passed++;
            total++; if (rises !== 1 || fs !== 1) $display("FAIL clamp f%0d edges: got rises=%0d fs=%0d want 1/1", f, rises, fs); else passed++;
        end
    endtask

    task automatic test_midframe();
        int hi, rises, fs; bit fs0, stable; logic [W-1:0] pw; logic st;
        measure_frame(100, W'(65), hi, rises, fs, fs0, pw, st, stable);
        total++; if (hi !== 230)         $display("FAIL midframe keep high: got %0d want 230", hi); else passed++;
        total++; if (rises !== 1)        $display("FAIL midframe keep rises: got %0d want 1", rises); else passed++;
        total++; if (st !== 1'b0)        $display("FAIL midframe keep settled: got %b want 0", st); else passed++;
        total++; if (!stable)            $display("FAIL midframe keep outputs: got unstable want stable"); else passed++;
        measure_frame(-1, '0, hi, rises, fs, fs0, pw, st, stable);
        total++; if (hi !== 65)          $display("FAIL midframe next high: got %0d want 65", hi); else passed++;
        total++; if (rises !== 1)        $display("FAIL midframe next rises: got %0d want 1", rises); else passed++;
        total++; if (pw !== W'(65))      $display("FAIL midframe next pulse_width: got %0d want 65", pw); else passed++;
    endtask

    task automatic test_release();
        int hi, rises, fs; bit fs0, stable; logic [W-1:0] pw; logic st;
        int set_v[4]  = '{0, 0, 0, 230};
        int exp_hi[4] = '{65, 0, 0, 0};
        for (int f = 0; f < 4; f++) begin
            ang.angle_value = W'(set_v[f]);
            measure_frame(-1, '0, hi, rises, fs, fs0, pw, st, stable);
            total++; if (hi !== exp_hi[f])     $display("FAIL release f%0d high: got %0d want %0d", f, hi, exp_hi[f]); else passed++;
            total++; if (pw !== W'(exp_hi[f])) $display("FAIL release f%0d pulse_width: got %0d want %0d", f, pw, exp_hi[f]); else passed++;
            total++; if (st !== 1'b0)          $display("FAIL release f%0d settled: got %b want 0", f, st); else passed++;
            total++; if (fs !== 1 || !fs0)     $display("FAIL release f%0d frame_start: got %0d (first=%0d) want 1", f, fs, fs0); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        int hi, rises, fs; bit fs0, stable; logic [W-1:0] pw; logic st;
        repeat (120) @(negedge clk);
        total++; if (servo_pwm !== 1'b1)        $display("FAIL rstmid pre pulse: got %b want 1", servo_pwm); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (servo_pwm !== 1'b0)        $display("FAIL rstmid servo_pwm: got %b want 0", servo_pwm); else passed++;
        total++; if (ang.frame_start !== 1'b0)  $display("FAIL rstmid frame_start: got %b want 0", ang.frame_start); else passed++;
        total++; if (ang.settled !== 1'b0)      $display("FAIL rstmid settled: got %b want 0", ang.settled); else passed++;
        total++; if (ang.pulse_width !== '0)    $display("FAIL rstmid pulse_width: got %0d want 0", ang.pulse_width); else passed++;
        ang.angle_value = W'(65);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        prev_pwm = 1'b0;
        sync_frame("rstmid");
        measure_frame(-1, '0, hi, rises, fs, fs0, pw, st, stable);
        total++; if (hi !== 65)                 $display("FAIL rstmid fresh high: got %0d want 65", hi); else passed++;
        total++; if (pw !== W'(65))             $display("FAIL rstmid fresh pulse_width: got %0d want 65", pw); else passed++;
        total++; if (st !== 1'b0)               $display("FAIL rstmid fresh settled: got %b want 0", st); else passed++;
    endtask

    task automatic test_alternate();
        int hi, rises, fs; bit fs0, stable; logic [W-1:0] pw; logic st;
        int exp_w;
        for (int f = 0; f < 6; f++) begin
            ang.angle_value = (f % 2 == 0) ? W'(230) : W'(65);
            exp_w = (f % 2 == 0) ? 65 : 230;
            measure_frame(-1, '0, hi, rises, fs, fs0, pw, st, stable);
            total++; if (hi !== exp_w)         $display("FAIL alternate f%0d high: got %0d want %0d", f, hi, exp_w); else passed++;
            total++; if (pw !== W'(exp_w))     $display("FAIL alternate f%0d pulse_width: got %0d want %0d", f, pw, exp_w); else passed++;
            total++; if (st !== 1'b0)          $display("FAIL alternate f%0d settled: got %b want 0", f, st); else passed++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ang.angle_value = '0;
        @(negedge clk);
        test_reset();
        test_steady();
        test_clamp();
        test_midframe();
        test_release();
        test_reset_mid();
        test_alternate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/servo_pwm_gen.md
Name: servo_pwm_gen

Overview:
- Consumer end of the `angle_value` interface driven by the marble-dispense controller.
- Converts the requested pulse width, given in clock cycles, into the periodic servo control waveform on the servo output pin.
- Samples the request once per PWM frame, clamps it to safe servo limits and treats 0 as "servo released".
- Reports back to the controller when a commanded position has been held long enough for the horn to settle.

Parameters:
- PERIOD_CYCLES, 2_000_000: frame length in clk cycles (20 ms at 100 MHz).
- MIN_PULSE, 50_000: lowest allowed non-zero high time in cycles (0.5 ms).
- MAX_PULSE, 250_000: highest allowed high time in cycles (2.5 ms).
- SETTLE_FRAMES, 25: consecutive identical frames before `settled` asserts (0.5 s).
- WIDTH, 21: width of `angle_value`.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous active-low reset.
- angle_value  input  WIDTH  requested high time in clk cycles; 0 means no pulses.
- servo_pwm  output  1  servo control pin, registered.
- frame_start  output  1  one-cycle strobe on the first cycle of every frame.
- settled  output  1  the same non-zero pulse width has been driven for SETTLE_FRAMES full frames.
- pulse_width  output  WIDTH  the width currently being driven after clamping; 0 when released.

Behaviour:
- Reset (rst_n low, asynchronous): all of the following are 0: `frame_cnt`, `shadow`, `settle_cnt`, `servo_pwm`, `frame_start`, `settled`, `pulse_width`. No pulse is emitted while in reset.
- Frame counter: `frame_cnt` counts 0..PERIOD_CYCLES-1 and wraps to 0. It free-runs from the first clk edge after rst_n deasserts.
- Sample point: on the edge where `frame_cnt` == PERIOD_CYCLES-1, or on the first edge after reset release, `angle_value` is sampled into `shadow`. The clamp rule is:
  - 0 -> 0
  - less than MIN_PULSE -> MIN_PULSE
  - greater than MAX_PULSE -> MAX_PULSE
  - otherwise unchanged.
- `pulse_width` = `shadow`. Changes to `angle_value` between sample points have no effect mid-frame, so no runt or stretched pulses can occur.
- Waveform: `servo_pwm` is high for exactly `shadow` cycles, starting on the first cycle of the frame. It is low for the rest of the frame. If `shadow` == 0, it stays low for the whole frame.
- `frame_start`: high for exactly one cycle, aligned with `frame_cnt` == 0. It pulses every frame, including released frames.
- FSM, updated at each sample point:
  - RELEASED: `shadow` == 0.
  - MOVING: non-zero and `settle_cnt` < SETTLE_FRAMES.
  - HOLDING: non-zero and `settle_cnt` >= SETTLE_FRAMES; `settled` = 1.
- Transitions at the sample point:
  - New clamped value differs from the old `shadow`: go to MOVING with `settle_cnt` = 0, or to RELEASED if the new value is 0.
  - New value equals the old one and is non-zero: `settle_cnt` increments, saturating at SETTLE_FRAMES. Enter HOLDING when it reaches SETTLE_FRAMES.
  - Any to RELEASED: `settled` drops on the same edge.
- `settled` is registered and changes only at a sample point, never mid-frame.
- Comparison rule: equality is checked on clamped values. For example, 10 and 20 both clamp to MIN_PULSE and count as "same".
- Arithmetic:
  - Counters are unsigned, with `frame_cnt` sized ceil(log2(PERIOD_CYCLES)) bits.
  - The clamp compares full WIDTH.
  - MAX_PULSE < PERIOD_CYCLES is required, so the pulse never fills a frame.
- Reset mid-frame: `servo_pwm` drops immediately (asynchronously). After release a fresh frame begins with a new sample; there is no partial-frame completion.

Decomposition:
- Shared package `servo_pkg`:
  - CLK_HZ
  - default PERIOD_CYCLES, MIN_PULSE, MAX_PULSE
  - the named widths used by the marble controller: ANGLE_DISPENSE = 230_000, ANGLE_HOME = 65_000
  - the FSM state encoding, as a 2-bit localparam set: RELEASED = 0, MOVING = 1, HOLDING = 2
- One natural sub-module, `servo_frame_timer`: the wrapping frame counter, producing `frame_cnt`, the sample strobe and `frame_start`.
- The clamp, shadow register, FSM and PWM compare stay in the top module.

Test Plan (sim overrides: PERIOD_CYCLES=1000, MIN_PULSE=50, MAX_PULSE=250, SETTLE_FRAMES=3):
1. Reset release with `angle_value` = 230 -> `frame_start` every 1000 cycles; `servo_pwm` high exactly 230 cycles per frame; `pulse_width` = 230; `settled` rises at the sample point ending frame 4 (after 3 matching frames) and stays 1.
2. `angle_value` = 10, then 400 -> first frames show 50-cycle pulses, then 250-cycle pulses after the next sample point; `settled` drops to 0 on the change and re-rises 3 frames later.
3. `angle_value` changes 230 -> 65 at `frame_cnt` = 100 -> current frame keeps its 230-cycle pulse; next frame is 65 cycles; no glitch, so exactly one rising edge per frame.
4. `angle_value` = 0 -> `servo_pwm` stays 0 for whole frames; `frame_start` still pulses; `settled` = 0; `pulse_width` = 0.
5. rst_n pulled low at `frame_cnt` = 120 during a 230-cycle pulse -> `servo_pwm` = 0 immediately; all outputs are 0; after release a new frame starts with a fresh sample and a full-length pulse.
6. Alternate 230/65 every frame, mimicking the dispense sequence -> `settled` never asserts; pulse widths follow the sequence with a one-frame sample latency.
